uart_tx_fifo: RTL and testbench

UART transmitter for the CA UART link. It mirrors the existing receiver's frame format: 8N1, LSB first, fixed CLKS_PER_BIT oversampling-free bit timing. Bytes are accepted over a valid/ready handshake into a small internal FIFO, then serialized back-to-back onto the TX line. It sits between the core's peripheral register interface and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter for the CA UART link. Bytes arrive over a valid/ready
// handshake into a small FIFO and are serialized back-to-back as 8N1 frames,
// LSB first, with a fixed number of clock cycles per serial bit.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the 8 data
//                      bits) is sent between the last data bit and the stop
//                      bit. When undefined the frame is plain 8N1.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries in the TX FIFO (power of 2, >= 2)
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Tx_DV       byte valid; pushed when o_Tx_Ready is also high
//   i_Tx_Byte     byte to queue, sampled on the push edge
//   o_Tx_Ready    FIFO not full
//   o_Tx_Serial   registered serial line, idle high
//   o_Tx_Active   high from start bit through stop bit
//   o_Tx_Done     one-cycle pulse after each stop bit
//   o_Fifo_Count  bytes queued, excluding the byte being shifted
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE  = CW'(1);
    localparam logic [CW-1:0] CLK_ZERO = '0;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [NW-1:0] CNT_ONE  = NW'(1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;
`endif

    state_t          state_q,  state_d;
    logic [CW-1:0]   clkCnt_q, clkCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      txByte_q, txByte_d;
    logic            serial_q, serial_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [NW-1:0]   count_q;

    logic            push;
    logic            pop;
    logic            bitEnd;

    assign o_Tx_Ready   = (count_q != CNT_FULL);
    assign o_Fifo_Count = count_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Done    = (state_q == CLEANUP);

    // A push while full is dropped because o_Tx_Ready gates it.
    assign push   = i_Tx_DV && o_Tx_Ready;
    assign bitEnd = (clkCnt_q == CLK_LAST);

    // Active covers every state that drives part of a frame on the line.
    always_comb begin
        o_Tx_Active = 1'b0;
        case (state_q)
            START, DATA, STOP: o_Tx_Active = 1'b1;
`ifdef UART_TX_PARITY_EN
            PARITY:            o_Tx_Active = 1'b1;
`endif
            default:           o_Tx_Active = 1'b0;
        endcase
    end

    // FIFO storage. Entries are not cleared on reset; clearing the pointers
    // and count is enough to discard them.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wrPtr_q] <= i_Tx_Byte;
        end
    end

    // FIFO pointers and occupancy. Push and pop on the same edge leave the
    // count unchanged.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmit state register; the serial line is registered so the pin
    // never glitches.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            clkCnt_q <= '0;
            bitIdx_q <= '0;
            txByte_q <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            clkCnt_q <= clkCnt_d;
            bitIdx_q <= bitIdx_d;
            txByte_q <= txByte_d;
            serial_q <= serial_d;
        end
    end

    // Next-state logic. Each state sets up the line value for the following
    // bit period at the moment it leaves, so the line changes exactly on the
    // bit boundary. IDLE only looks at the registered count, so a byte pushed
    // into an empty FIFO is popped one edge later.
    always_comb begin
        state_d  = state_q;
        clkCnt_d = clkCnt_q;
        bitIdx_d = bitIdx_q;
        txByte_d = txByte_q;
        serial_d = serial_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                clkCnt_d = CLK_ZERO;
                bitIdx_d = 3'd0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    txByte_d = mem[rdPtr_q];
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (bitEnd) begin
                    clkCnt_d = CLK_ZERO;
                    bitIdx_d = 3'd0;
                    serial_d = txByte_q[0];
                    state_d  = DATA;
                end else begin
                    clkCnt_d = clkCnt_q + CLK_ONE;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    clkCnt_d = CLK_ZERO;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        serial_d = ^txByte_q;
                        state_d  = PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        serial_d = txByte_q[bitIdx_q + 3'd1];
                    end
                end else begin
                    clkCnt_d = clkCnt_q + CLK_ONE;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    clkCnt_d = CLK_ZERO;
                    serial_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    clkCnt_d = clkCnt_q + CLK_ONE;
                end
            end
`endif

            STOP: begin
                if (bitEnd) begin
                    clkCnt_d = CLK_ZERO;
                    serial_d = 1'b1;
                    state_d  = CLEANUP;
                end else begin
                    clkCnt_d = clkCnt_q + CLK_ONE;
                end
            end

            CLEANUP: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                serial_d = 1'b1;
                clkCnt_d = CLK_ZERO;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Randomized and directed testbench for uart_tx_fifo with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. A timing reference model predicts every output per cycle from
// frame arithmetic (cycles since a byte was taken), and a serial monitor
// decodes frames off the line and compares them against a scoreboard of
// accepted bytes. Honours UART_TX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM   = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NSYM   = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME = NSYM * CPB;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       txDv   = 1'b0;
    logic [7:0] txByte = 8'h00;
    logic       txReady;
    logic       txSerial;
    logic       txActive;
    logic       txDone;
    logic [2:0] fifoCount;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] pendQ[$];
    logic [7:0] expQ[$];
    bit         mBusy = 1'b0;
    int         mT    = 0;
    logic [7:0] mCur  = 8'h00;
    int         mSz;
    bit         mPush;
    bit         checkEn = 1'b0;

    // Monitor state.
    bit         monBusy = 1'b0;
    int         monT    = 0;
    int         monSym;
    logic [7:0] monByte = 8'h00;
    logic       monPar  = 1'b0;
    logic [7:0] monExp;
    int         framesSeen = 0;
    int         doneSeen   = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (clock),
        .i_Reset      (reset),
        .i_Tx_DV      (txDv),
        .i_Tx_Byte    (txByte),
        .o_Tx_Ready   (txReady),
        .o_Tx_Serial  (txSerial),
        .o_Tx_Active  (txActive),
        .o_Tx_Done    (txDone),
        .o_Fifo_Count (fifoCount)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line value the model predicts from the position inside the frame.
    function automatic logic expSerial();
        if (!mBusy || mT >= FRAME) return 1'b1;
        if (mT < CPB)              return 1'b0;
        if (mT < 9 * CPB)          return mCur[mT / CPB - 1];
        if (PAR_EN && mT < 10 * CPB) return ^mCur;
        return 1'b1;
    endfunction

    // Reference model: a queue of accepted bytes and a frame timer. A byte is
    // taken only when the transmitter was already idle before the edge, then
    // occupies FRAME cycles of line plus one done cycle and one idle cycle.
    always @(posedge clock) begin
        mSz = pendQ.size();
        if (reset) begin
            pendQ.delete();
            expQ.delete();
            mBusy = 1'b0;
            mT    = 0;
        end else begin
            mPush = txDv && (mSz < DEPTH);
            if (mBusy) begin
                mT++;
                if (mT == FRAME + 1) mBusy = 1'b0;
            end else if (mSz > 0) begin
                mCur  = pendQ.pop_front();
                mBusy = 1'b1;
                mT    = 0;
            end
            if (mPush) begin
                pendQ.push_back(txByte);
                expQ.push_back(txByte);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("serial", txSerial, expSerial());
            checkOutput("active", txActive, mBusy && (mT < FRAME));
            checkOutput("done",   txDone,   mBusy && (mT == FRAME));
            checkOutput("count",  fifoCount, pendQ.size());
            checkOutput("ready",  txReady,  pendQ.size() < DEPTH);
            if (txDone === 1'b1) doneSeen++;
        end
    end

    // Serial monitor: finds a start bit, samples each symbol mid-bit and on the
    // stop bit pops the scoreboard to compare the decoded byte.
    always @(negedge clock) begin
        if (reset || !checkEn) begin
            monBusy = 1'b0;
        end else if (!monBusy) begin
            if (txSerial === 1'b0) begin
                monBusy = 1'b1;
                monT    = 0;
            end
        end else begin
            monT++;
            if ((monT % CPB) == CPB / 2) begin
                monSym = monT / CPB;
                if (monSym == 0) begin
                    checkOutput("start bit", txSerial, 1'b0);
                end else if (monSym <= 8) begin
                    monByte[monSym - 1] = txSerial;
                end else if (PAR_EN && monSym == 9) begin
                    monPar = txSerial;
                end
                if (monSym == NSYM - 1) begin
                    checkOutput("stop bit", txSerial, 1'b1);
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected frame: got %0h, expected no frame", monByte);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput("frame byte", monByte, monExp);
                        if (PAR_EN) checkOutput("parity bit", monPar, ^monExp);
                    end
                    framesSeen++;
                    monBusy = 1'b0;
                end
            end
        end
    end

    // Drive one byte for one cycle; called at posedge+1.
    task automatic applyStimulus(input logic dv, input logic [7:0] b);
        txDv   = dv;
        txByte = b;
        @(posedge clock);
        #1;
        txDv = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Wait until the model has nothing left to send, bounded.
    task automatic drain();
        int n;
        n = 0;
        while ((mBusy || pendQ.size() > 0) && n < 20 * (FRAME + 2)) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (mBusy || pendQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain timeout: got %0d queued, expected 0", pendQ.size());
        end
        idleCycles(3);
        checkOutput("scoreboard empty", expQ.size(), 0);
    endtask

    initial begin
        int startFrames;
        int startDone;
        int n;

        // Reset held for three cycles.
        reset = 1'b1;
        idleCycles(3);
        checkOutput("reset serial", txSerial,  1'b1);
        checkOutput("reset ready",  txReady,   1'b1);
        checkOutput("reset count",  fifoCount, 3'd0);
        checkOutput("reset active", txActive,  1'b0);
        checkOutput("reset done",   txDone,    1'b0);
        checkEn = 1'b1;
        reset   = 1'b0;
        idleCycles(2);

        // Single byte.
        applyStimulus(1'b1, 8'hA5);
        drain();

        // Three consecutive pushes.
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'hFF);
        drain();

        // Overflow: six consecutive pushes, the sixth finds the FIFO full.
        startFrames = framesSeen;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'($urandom));
        end
        checkOutput("ready when full", txReady, 1'b0);
        checkOutput("count when full", fifoCount, 3'd4);
        drain();
        checkOutput("overflow frames", framesSeen - startFrames, 5);

        // Reset during data bit 3 with two bytes queued.
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b1, 8'hC3);
        n = 0;
        while (!(mBusy && mT == 4 * CPB + 1) && n < 4 * FRAME) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("reached data bit 3", mBusy && mT == 4 * CPB + 1, 1'b1);
        startFrames = framesSeen;
        startDone   = doneSeen;
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("serial after reset", txSerial,  1'b1);
        checkOutput("count after reset",  fifoCount, 3'd0);
        idleCycles(3 * (FRAME + 2));
        checkOutput("frames after reset", framesSeen - startFrames, 0);
        checkOutput("done after reset",   doneSeen - startDone, 0);

        // Parity-relevant bytes (plain frames when parity is off).
        applyStimulus(1'b1, 8'h07);
        applyStimulus(1'b1, 8'h03);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
